vga_timing_pipe: RTL and testbench
==================================

# vga_timing_pipe

Parametrised VGA timing and pixel-fetch controller; successor to the fixed 640x480 controller. Generates programmable-resolution sync timing, issues pixel RAM read addresses with optional integer pixel replication (1x/2x/4x), and compensates a configurable frame-buffer read latency so RGB, HS, VS and status strobes leave the block mutually aligned. Sits between the frame buffer and the board VGA pins. It also supplies frame and vblank strobes to the game logic.

## Interface
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, horizontal visible pixels
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, vertical visible lines
- V_FRONT, 10, vertical front porch
- HS_POL, 0, sync active level for HS (0 = active-low)
- VS_POL, 0, sync active level for VS
- COLOR_W, 4, bits per colour channel
- RD_LAT, 1, pixel RAM read latency in pixel ticks, legal 0..4
- SCALE_SHIFT, 0, replication factor log2, legal 0..2
- ROW_W, 9, row address width; COL_W, 10, col address width

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; all state advances only when high
- Din  in  3*COLOR_W  pixel {B,G,R}, R in LSBs
- row  out  ROW_W  pixel RAM row address (scaled)
- col  out  COL_W  pixel RAM col address (scaled)
- rdn  out  1  read strobe, active-low
- R, G, B  out  COLOR_W each  colour outputs
- HS, VS  out  1  sync outputs
- frame_start  out  1  one-clk pulse at first output pixel (h=0, v=0)
- vblank  out  1  high while the output line is outside the active region

## Operation
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. h_cnt counts 0..H_TOTAL-1; v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, then wraps to 0. Both counters advance only on pix_en.
- Region order in h and v: sync, back porch, active, front porch. Active when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, likewise for v.
- Address stage, registered on pix_en: col = (h_cnt-H_SYNC-H_BACK)>>SCALE_SHIFT; row = (v_cnt-V_SYNC-V_BACK)>>SCALE_SHIFT. Both are truncated to width. rdn = ~active.
- Outside active, row/col hold the truncated arithmetic value (don't-care); rdn=1 is authoritative.
- Alignment: raw HS, VS, active, vblank and frame flag pass through a pix_en-gated delay line of RD_LAT stages. Din is sampled on the same tick that the delayed flags emerge.
- Output stage: R,G,B = delayed active ? Din fields : 0. HS = HS_POL when the delayed h is in sync, else ~HS_POL; VS likewise.
- frame_start is high for exactly one clk: the clk whose pix_en edge updates the outputs for (h=0, v=0). It is low on all other clks, including non-pix_en clks.
- vblank = delayed (v_cnt outside active region). It is level, not pulse.
- Width rule: COL_W/ROW_W must hold H_ACTIVE>>SCALE_SHIFT-1 and V_ACTIVE>>SCALE_SHIFT-1; the h/v counters are sized internally to hold H_TOTAL-1 and V_TOTAL-1.

## Timing
- Reset values (forced on the clk edge with rst=1, regardless of pix_en): h_cnt=v_cnt=0, row=col=0, rdn=1, R=G=B=0, HS=~HS_POL, VS=~VS_POL, frame_start=0, vblank=1, all delay stages cleared to blank/inactive-sync.
- Latency, in pix_en ticks, from counter value to the outputs showing that pixel: address = 1; RGB/HS/VS/vblank/frame_start = RD_LAT+2.
- Din requirement: Din must hold data for the presented row/col RD_LAT ticks after that address appears.
- pix_en low: every register holds and frame_start is forced 0. pix_en tied high gives one pixel per clk.
- Wrap: h_cnt=H_TOTAL-1 with v_cnt=V_TOTAL-1 goes to (0,0) on the next tick with no idle tick.
- Reset mid-frame: the next tick after rst deasserts starts at (0,0). The first frame_start occurs RD_LAT+2 ticks after that. No stale colour is emitted from the flushed pipeline.

## Test plan
- Defaults, pix_en=1, reset released. Required: HS period 800 clks, low for 96; VS low for 2 lines (1600 clks) per 420000 clks; frame_start every 420000 clks.
- RD_LAT=2, Din = f(row,col) modelled by a 2-cycle RAM. Required: every visible pixel shows f(row,col) of its own coordinate, and the first visible R after HS rises appears at h=144.
- SCALE_SHIFT=1. Required: col sequence 0,0,1,1,...,319,319 per line; row increments every 2 lines, 0..239.
- HS_POL=1, VS_POL=1, small custom timing (H=4/2/8/2, V=1/1/4/1). Required: HS high for exactly 4 of 16 ticks; total frame = 112 ticks.
- pix_en asserted 1 clk in 4. Required: all periods scale by 4; frame_start width = 1 clk.
- rst asserted at h=300, v=200 for 1 clk. Required: outputs show reset values next cycle; RGB stays 0 until the first active pixel of the new frame.

Source files
------------

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: programmable VGA sync/address generator with read-latency-aligned RGB and status outputs
module vga_timing_pipe #(
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 10,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int COLOR_W = 4,
  parameter int RD_LAT = 1,
  parameter int SCALE_SHIFT = 0,
  parameter int ROW_W = 9,
  parameter int COL_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic [3*COLOR_W-1:0] Din,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic rdn,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic HS,
  output logic VS,
  output logic frame_start,
  output logic vblank
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0 = H_SYNC + H_BACK;
  localparam int HA1 = HA0 + H_ACTIVE;
  localparam int VA0 = V_SYNC + V_BACK;
  localparam int VA1 = VA0 + V_ACTIVE;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic vb;
    logic fs;
  } flags_t;
  localparam flags_t IDLE = '{hs: 1'b0, vs: 1'b0, act: 1'b0, vb: 1'b1, fs: 1'b0};
  logic [HW-1:0] h_cnt, h_off;
  logic [VW-1:0] v_cnt, v_off;
  logic h_act, v_act, h_last, v_last;
  flags_t raw;
  // dly[0] is the address-stage copy; dly[RD_LAT] lines up with Din
  flags_t dly [RD_LAT+1];
  always_comb begin
    h_act = int'(h_cnt) >= HA0 && int'(h_cnt) < HA1;
    v_act = int'(v_cnt) >= VA0 && int'(v_cnt) < VA1;
    h_last = int'(h_cnt) == H_TOTAL - 1;
    v_last = int'(v_cnt) == V_TOTAL - 1;
    h_off = h_cnt - HW'(HA0);
    v_off = v_cnt - VW'(VA0);
    raw = '{hs: int'(h_cnt) < H_SYNC, vs: int'(v_cnt) < V_SYNC, act: h_act && v_act,
            vb: !v_act, fs: h_cnt == '0 && v_cnt == '0};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      row <= '0;
      col <= '0;
      rdn <= 1'b1;
      {B, G, R} <= '0;
      HS <= ~HS_POL;
      VS <= ~VS_POL;
      frame_start <= 1'b0;
      vblank <= 1'b1;
      for (int i = 0; i <= RD_LAT; i++) dly[i] <= IDLE;
    end else begin
      frame_start <= pix_en && dly[RD_LAT].fs;
      if (pix_en) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        col <= COL_W'(h_off >> SCALE_SHIFT);
        row <= ROW_W'(v_off >> SCALE_SHIFT);
        rdn <= !raw.act;
        dly[0] <= raw;
        for (int i = 1; i <= RD_LAT; i++) dly[i] <= dly[i-1];
        {B, G, R} <= dly[RD_LAT].act ? Din : '0;
        HS <= dly[RD_LAT].hs ? HS_POL : ~HS_POL;
        VS <= dly[RD_LAT].vs ? VS_POL : ~VS_POL;
        vblank <= dly[RD_LAT].vb;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: directed checks on two small-timing instances (latency 2 RAM, and 2x replication)
module tb_vga_timing_pipe;
  logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] row0, col0, R0, G0, B0;
  logic rdn0, HS0, VS0, fs0, vb0;
  logic [11:0] din0, m1, m2;
  logic [2:0] row1, col1;
  logic [3:0] R1, G1, B1;
  logic rdn1, HS1, VS1, fs1, vb1;
  logic [11:0] din1;
  int checks = 0, errs = 0, n = 0;
  int fsc, hsc, clr, first_fs, second_fs;
  function automatic logic [11:0] f(input logic [3:0] r, input logic [3:0] c);
    return {c ^ r ^ 4'd5, r + 4'd2, c + 4'd1};
  endfunction
  // two-tick frame-buffer model for u0
  always @(posedge clk) if (pix_en) begin
    m1 <= f(row0, col0);
    m2 <= m1;
  end
  assign din0 = m2;
  assign din1 = f({1'b0, row1}, {1'b0, col1});
  vga_timing_pipe #(
    .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .RD_LAT(2), .SCALE_SHIFT(0),
    .ROW_W(4), .COL_W(4)
  ) u0 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .Din(din0), .row(row0), .col(col0), .rdn(rdn0),
    .R(R0), .G(G0), .B(B0), .HS(HS0), .VS(VS0), .frame_start(fs0), .vblank(vb0)
  );
  vga_timing_pipe #(
    .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .RD_LAT(0), .SCALE_SHIFT(1),
    .ROW_W(3), .COL_W(3)
  ) u1 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .Din(din1), .row(row1), .col(col1), .rdn(rdn1),
    .R(R1), .G(G1), .B(B1), .HS(HS1), .VS(VS1), .frame_start(fs1), .vblank(vb1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask
  task automatic go(input int t);
    while (n < t) step();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdn", 32'(rdn0), 1);
    chk("rst_hs0", 32'(HS0), 0);
    chk("rst_vs0", 32'(VS0), 0);
    chk("rst_vb0", 32'(vb0), 1);
    chk("rst_fs0", 32'(fs0), 0);
    chk("rst_rgb0", 32'({B0, G0, R0}), 0);
    chk("rst_row0", 32'(row0), 0);
    chk("rst_col0", 32'(col0), 0);
    chk("rst_hs1", 32'(HS1), 1);
    chk("rst_vs1", 32'(VS1), 1);
    rst = 1'b0;
    pix_en = 1'b1;
    go(1);  chk("rdn_blank", 32'(rdn0), 1);
    go(2);  chk("fs1_on", 32'(fs1), 1); chk("hs1_sync", 32'(HS1), 0);
    go(3);  chk("fs0_early", 32'(fs0), 0); chk("fs1_off", 32'(fs1), 0);
    go(4);  chk("fs0_on", 32'(fs0), 1); chk("hs0_on", 32'(HS0), 1); chk("vs0_on", 32'(VS0), 1);
    chk("vb0_top", 32'(vb0), 1); chk("hs1_back", 32'(HS1), 1);
    go(5);  chk("fs0_width", 32'(fs0), 0);
    go(8);  chk("hs0_off", 32'(HS0), 0);
    go(20); chk("hs0_line1", 32'(HS0), 1); chk("vs0_off", 32'(VS0), 0); chk("vb0_back", 32'(vb0), 1);
    for (int i = 0; i < 8; i++) begin
      go(33 + i);
      chk("col1_rep", 32'(col1), 32'(i >> 1));
      chk("rdn1_act", 32'(rdn1), 0);
      if (i == 1) begin
        chk("r1_px0", 32'(R1), 1);
        chk("g1_px0", 32'(G1), 2);
      end
      if (i == 3) chk("r1_px2", 32'(R1), 2);
      if (i == 6) begin
        chk("row0_first", 32'(row0), 0);
        chk("col0_first", 32'(col0), 0);
        chk("rdn0_first", 32'(rdn0), 0);
      end
    end
    go(41); chk("r0_pre", 32'(R0), 0);
    go(42); chk("r0_first", 32'(R0), 1); chk("g0_first", 32'(G0), 2); chk("b0_first", 32'(B0), 5);
    chk("vb0_act", 32'(vb0), 0);
    go(49); chk("r0_last", 32'(R0), 8); chk("g0_last", 32'(G0), 2); chk("b0_last", 32'(B0), 2);
    go(50); chk("r0_front", 32'(R0), 0);
    go(61); chk("row1_rep", 32'(row1), 1);
    go(90); chk("r0_row3", 32'(R0), 1); chk("g0_row3", 32'(G0), 5); chk("b0_row3", 32'(B0), 6);
    go(100); chk("vb0_front", 32'(vb0), 1);
    fsc = 0;
    hsc = 0;
    for (int i = 101; i <= 116; i++) begin
      go(i);
      fsc += 32'(fs0);
      hsc += 32'(HS0);
    end
    chk("fs0_count", 32'(fsc), 1);
    chk("hs0_width", 32'(hsc), 4);
    chk("fs0_wrap", 32'(fs0), 1);
    go(156); chk("r0_frame2", 32'(R0), 3);
    rst = 1'b1;
    step();
    chk("mid_rgb", 32'({B0, G0, R0}), 0);
    chk("mid_hs", 32'(HS0), 0);
    chk("mid_vs", 32'(VS0), 0);
    chk("mid_vb", 32'(vb0), 1);
    chk("mid_rdn", 32'(rdn0), 1);
    chk("mid_col", 32'(col0), 0);
    rst = 1'b0;
    n = 0;
    clr = 0;
    fsc = 0;
    for (int i = 1; i <= 41; i++) begin
      go(i);
      if ({B0, G0, R0} != 12'd0) clr++;
      fsc += 32'(fs0);
    end
    chk("flush_rgb", 32'(clr), 0);
    chk("flush_fs", 32'(fsc), 1);
    go(42); chk("flush_first", 32'(R0), 1);
    rst = 1'b1;
    pix_en = 1'b0;
    step();
    rst = 1'b0;
    fsc = 0;
    hsc = 0;
    first_fs = -1;
    second_fs = -1;
    for (int c = 0; c < 480; c++) begin
      pix_en = (c % 4 == 0);
      @(posedge clk);
      #1;
      if (fs0) begin
        fsc++;
        if (first_fs < 0) first_fs = c;
        else if (second_fs < 0) second_fs = c;
      end
      if (c >= 12 && c <= 75) hsc += 32'(HS0);
    end
    chk("slow_fs_count", 32'(fsc), 2);
    chk("slow_fs_first", 32'(first_fs), 12);
    chk("slow_fs_second", 32'(second_fs), 460);
    chk("slow_hs_width", 32'(hsc), 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
